fpu_wb_regs: RTL and testbench

//  Wishbone classic slave register file that fronts the FPU in the user project area.
//  It decodes management-core writes of operands, rounding mode and operation word, and launches one FPU operation per OP write.
//  It captures the FPU result and exception flags for readback.

---
 rtl/fpu_wb_pkg.sv | 60 ++++++
 rtl/fpu_wb_if.sv | 25 ++
 rtl/fpu_wb_launch.sv | 91 +++++++++
 rtl/fpu_wb_regs.sv | 183 ++++++++++++++++++
 tb/tb_fpu_wb_regs.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_wb_pkg.sv
// fpu_wb_pkg
// Shared definitions for the FPU Wishbone register block.
// Contents:
//   - Register byte offsets (A_OFS .. RM_OFS) within the 256-byte window.
//   - STATUS register bit positions.
//   - Launch FSM state encoding.
//   - One-hot FPU operation constants for op_o.
//   - byte_merge helper that applies a Wishbone byte-select write to a word.
package fpu_wb_pkg;

  localparam logic [7:0] A_OFS      = 8'h00;
  localparam logic [7:0] B_OFS      = 8'h04;
  localparam logic [7:0] C_OFS      = 8'h08;
  localparam logic [7:0] RESULT_OFS = 8'h0C;
  localparam logic [7:0] FLAGS_OFS  = 8'h10;
  localparam logic [7:0] STATUS_OFS = 8'h14;
  localparam logic [7:0] OP_OFS     = 8'h1C;
  localparam logic [7:0] IRQEN_OFS  = 8'h20;
  localparam logic [7:0] RM_OFS     = 8'h24;

  localparam int STAT_BUSY        = 0;
  localparam int STAT_DONE        = 1;
  localparam int STAT_ERR_OVERRUN = 2;
  localparam int STAT_ERR_TIMEOUT = 3;

  // Bit of the OP word that requests a launch; it is never stored.
  localparam int OP_VALID_BIT = 12;

  typedef enum logic [1:0] {
    LAUNCH_IDLE  = 2'd0,
    LAUNCH_ISSUE = 2'd1,
    LAUNCH_WAIT  = 2'd2
  } launch_state_e;

  localparam logic [11:0] OP_ADD    = 12'h001;
  localparam logic [11:0] OP_SUB    = 12'h002;
  localparam logic [11:0] OP_MUL    = 12'h004;
  localparam logic [11:0] OP_DIV    = 12'h008;
  localparam logic [11:0] OP_SQRT   = 12'h010;
  localparam logic [11:0] OP_FMADD  = 12'h020;
  localparam logic [11:0] OP_MIN    = 12'h040;
  localparam logic [11:0] OP_MAX    = 12'h080;
  localparam logic [11:0] OP_CMP    = 12'h100;
  localparam logic [11:0] OP_CVTFI  = 12'h200;
  localparam logic [11:0] OP_CVTIF  = 12'h400;
  localparam logic [11:0] OP_SGNJ   = 12'h800;

  // Replace only the bytes of cur whose select bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = wdat[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/fpu_wb_if.sv
// fpu_wb_if
// Wishbone classic slave bus as seen from the Caravel management core.
// Signals keep the wbs_* names of the Caravel user-project wrapper.
//   master modport: drives stb/cyc/we/sel/adr/dat_i, receives ack/dat_o
//   slave  modport: the register block side
interface fpu_wb_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/fpu_wb_launch.sv
// fpu_wb_launch
// Launch sequencer for one FPU operation at a time, IDLE -> ISSUE -> WAIT -> IDLE.
// Also owns the STATUS bits and the reply timeout counter.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   op_launch_wr    accepted OP write carrying the valid bit
//   result_rd       accepted read of RESULT (clears done)
//   fpu_valid_i     FPU result valid
//   launch_accept   op_launch_wr taken as a new launch (comb, for operand snapshot)
//   result_capture  FPU reply accepted this cycle (comb, loads RESULT/FLAGS)
//   valid_o         one-cycle launch pulse to the FPU
//   busy, done, err_overrun, err_timeout   STATUS bits
module fpu_wb_launch
  import fpu_wb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic op_launch_wr,
  input  logic result_rd,
  input  logic fpu_valid_i,
  output logic launch_accept,
  output logic result_capture,
  output logic valid_o,
  output logic busy,
  output logic done,
  output logic err_overrun,
  output logic err_timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  launch_state_e    state;
  logic [CNT_W-1:0] timer;

  assign launch_accept  = op_launch_wr && (state == LAUNCH_IDLE);
  assign result_capture = fpu_valid_i && (state == LAUNCH_WAIT);

  // The status bits change on the edge entering ISSUE so they are already
  // valid while valid_o is high. A RESULT read clears done first, so a reply
  // landing in the same cycle still leaves done set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LAUNCH_IDLE;
      timer       <= '0;
      valid_o     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (result_rd) done <= 1'b0;
      case (state)
        LAUNCH_IDLE: begin
          if (launch_accept) begin
            state       <= LAUNCH_ISSUE;
            valid_o     <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
          end
        end
        LAUNCH_ISSUE: begin
          state <= LAUNCH_WAIT;
          timer <= '0;
          if (op_launch_wr) err_overrun <= 1'b1;
        end
        LAUNCH_WAIT: begin
          if (op_launch_wr) err_overrun <= 1'b1;
          if (fpu_valid_i) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= LAUNCH_IDLE;
          end else if (timer == CNT_LAST) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= LAUNCH_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= LAUNCH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fpu_wb_regs.sv
// fpu_wb_regs
// Wishbone classic slave register file in front of the FPU core.
// Decodes A/B/C/RM/OP writes, launches one FPU op per OP write with bit 12
// set, and captures the FPU result and exception flags for readback.
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wbs                  Wishbone slave (fpu_wb_if.slave)
//   a_o, b_o, c_o        operands, snapshot taken at launch
//   op_o, rm_o           one-hot op and rounding mode, snapshot at launch
//   valid_o              one-cycle launch pulse
//   fpu_valid_i, fpu_result_i, fpu_flags_i   FPU reply
//   irq_o                completion interrupt
// Build option FPU_WB_IRQ_EN: adds the IRQEN register (offset 20) and drives
// irq_o = done & IRQEN[0]; otherwise irq_o is 0 and offset 20 is unmapped.
module fpu_wb_regs
  import fpu_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  fpu_wb_if.slave     wbs,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [11:0] op_o,
  output logic [2:0]  rm_o,
  output logic        valid_o,
  input  logic        fpu_valid_i,
  input  logic [31:0] fpu_result_i,
  input  logic [4:0]  fpu_flags_i,
  output logic        irq_o
);

  logic [31:0] a_q, b_q, c_q, result_q;
  logic [11:0] op_q;
  logic [2:0]  rm_q;
  logic [4:0]  flags_q;
  logic        ack_q;
  logic [31:0] dat_q;
  logic [31:0] rd_data;
  logic        irqen_bit;

  logic        adr_hit, access, wr_en, rd_en;
  logic [7:0]  ofs;
  logic        wr_a, wr_b, wr_c, wr_op, wr_rm;
  logic [31:0] op_merged;
  logic [11:0] op_new;
  logic        op_valid_wr, result_rd;
  logic        launch_accept, result_capture;
  logic        busy, done, err_overrun, err_timeout;
  logic        unused_bits;

  // An access is taken only while ack is low, so acks are never back to back.
  assign adr_hit = (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign ofs     = {wbs.wbs_adr_i[7:2], 2'b00};
  assign access  = wbs.wbs_stb_i & wbs.wbs_cyc_i & adr_hit & ~ack_q;
  assign wr_en   = access & wbs.wbs_we_i;
  assign rd_en   = access & ~wbs.wbs_we_i;

  assign wr_a  = wr_en && (ofs == A_OFS);
  assign wr_b  = wr_en && (ofs == B_OFS);
  assign wr_c  = wr_en && (ofs == C_OFS);
  assign wr_op = wr_en && (ofs == OP_OFS);
  assign wr_rm = wr_en && (ofs == RM_OFS);

  // The valid bit lives in byte 1, so it only counts when that byte is selected.
  assign op_merged   = byte_merge({20'b0, op_q}, wbs.wbs_dat_i, wbs.wbs_sel_i);
  assign op_new      = op_merged[11:0];
  assign op_valid_wr = wr_op & wbs.wbs_sel_i[1] & wbs.wbs_dat_i[OP_VALID_BIT];
  assign result_rd   = rd_en && (ofs == RESULT_OFS);

  assign unused_bits = ^{wbs.wbs_adr_i[1:0], op_merged[31:12]};

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;

  fpu_wb_launch #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_launch (
    .clk            (wb_clk_i),
    .rst            (wb_rst_i),
    .op_launch_wr   (op_valid_wr),
    .result_rd      (result_rd),
    .fpu_valid_i    (fpu_valid_i),
    .launch_accept  (launch_accept),
    .result_capture (result_capture),
    .valid_o        (valid_o),
    .busy           (busy),
    .done           (done),
    .err_overrun    (err_overrun),
    .err_timeout    (err_timeout)
  );

  // Register file. Operands and mode are snapshotted into the FPU-facing
  // outputs at launch, so writes made while busy never disturb the op in
  // flight. A valid OP write while busy is dropped entirely.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      op_q     <= '0;
      rm_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      a_o      <= '0;
      b_o      <= '0;
      c_o      <= '0;
      op_o     <= '0;
      rm_o     <= '0;
    end else begin
      if (wr_a) a_q <= byte_merge(a_q, wbs.wbs_dat_i, wbs.wbs_sel_i);
      if (wr_b) b_q <= byte_merge(b_q, wbs.wbs_dat_i, wbs.wbs_sel_i);
      if (wr_c) c_q <= byte_merge(c_q, wbs.wbs_dat_i, wbs.wbs_sel_i);
      if (wr_rm && wbs.wbs_sel_i[0]) rm_q <= wbs.wbs_dat_i[2:0];
      if (wr_op && !(op_valid_wr && busy)) op_q <= op_new;
      if (launch_accept) begin
        a_o  <= a_q;
        b_o  <= b_q;
        c_o  <= c_q;
        rm_o <= rm_q;
        op_o <= op_new;
      end
      if (result_capture) begin
        result_q <= fpu_result_i;
        flags_q  <= fpu_flags_i;
      end
    end
  end

`ifdef FPU_WB_IRQ_EN
  logic irqen_q;

  // Interrupt enable; clearing it drops a pending irq immediately.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irqen_q <= 1'b0;
    end else if (wr_en && (ofs == IRQEN_OFS) && wbs.wbs_sel_i[0]) begin
      irqen_q <= wbs.wbs_dat_i[0];
    end
  end

  assign irqen_bit = irqen_q;
  assign irq_o     = done & irqen_q;
`else
  assign irqen_bit = 1'b0;
  assign irq_o     = 1'b0;
`endif

  // Read mux; the OP valid bit is not stored and therefore reads back 0.
  always_comb begin
    rd_data = '0;
    case (ofs)
      A_OFS:      rd_data = a_q;
      B_OFS:      rd_data = b_q;
      C_OFS:      rd_data = c_q;
      RESULT_OFS: rd_data = result_q;
      FLAGS_OFS:  rd_data = {27'b0, flags_q};
      STATUS_OFS: begin
        rd_data[STAT_BUSY]        = busy;
        rd_data[STAT_DONE]        = done;
        rd_data[STAT_ERR_OVERRUN] = err_overrun;
        rd_data[STAT_ERR_TIMEOUT] = err_timeout;
      end
      OP_OFS:     rd_data = {20'b0, op_q};
      IRQEN_OFS:  rd_data = {31'b0, irqen_bit};
      RM_OFS:     rd_data = {29'b0, rm_q};
      default:    rd_data = '0;
    endcase
  end

  // Ack and read data are registered together, one cycle after the access.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= access;
      dat_q <= rd_en ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_fpu_wb_regs.sv
// tb_fpu_wb_regs
// Self-checking bench for fpu_wb_regs: directed scenarios with literal
// expectations plus a randomized phase, all compared against a register-level
// model of the block kept in this file. A negedge monitor checks launch
// pulses, operand snapshots, irq_o and the single-cycle ack on every cycle.
module tb_fpu_wb_regs;
  import fpu_wb_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_o, b_o, c_o;
  logic [11:0] op_o;
  logic [2:0]  rm_o;
  logic        valid_o, irq_o;
  logic        fpu_valid = 1'b0;
  logic [31:0] fpu_result = '0;
  logic [4:0]  fpu_flags = '0;

  fpu_wb_if bus ();

  fpu_wb_regs #(.BASE_ADR(BASE), .TIMEOUT_CYC(TIMEOUT)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs          (bus),
    .a_o          (a_o),
    .b_o          (b_o),
    .c_o          (c_o),
    .op_o         (op_o),
    .rm_o         (rm_o),
    .valid_o      (valid_o),
    .fpu_valid_i  (fpu_valid),
    .fpu_result_i (fpu_result),
    .fpu_flags_i  (fpu_flags),
    .irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: register contents and status bits.
  logic [31:0] m_a, m_b, m_c, m_result;
  logic [11:0] m_op;
  logic [2:0]  m_rm;
  logic [4:0]  m_flags;
  logic        m_irqen, m_busy, m_done, m_errov, m_errto;
  logic [31:0] exp_a, exp_b, exp_c;
  logic [11:0] exp_op;
  logic [2:0]  exp_rm;
  int          exp_pulses = 0;
  int          seen_pulses = 0;
  logic        ack_prev = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_c = '0; m_result = '0; m_op = '0; m_rm = '0;
    m_flags = '0; m_irqen = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    m_errov = 1'b0; m_errto = 1'b0;
  endtask

  function automatic logic model_irq();
`ifdef FPU_WB_IRQ_EN
    return m_done & m_irqen;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] ofs);
    case (ofs)
      8'h00: return m_a;
      8'h04: return m_b;
      8'h08: return m_c;
      8'h0C: return m_result;
      8'h10: return {27'b0, m_flags};
      8'h14: return {28'b0, m_errto, m_errov, m_done, m_busy};
      8'h1C: return {20'b0, m_op};
`ifdef FPU_WB_IRQ_EN
      8'h20: return {31'b0, m_irqen};
`endif
      8'h24: return {29'b0, m_rm};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [7:0] ofs, input logic [31:0] d,
                             input logic [3:0] sel);
    logic [31:0] mk, op_full;
    mk = sel_mask(sel);
    case (ofs)
      8'h00: m_a = (m_a & ~mk) | (d & mk);
      8'h04: m_b = (m_b & ~mk) | (d & mk);
      8'h08: m_c = (m_c & ~mk) | (d & mk);
      8'h24: if (sel[0]) m_rm = d[2:0];
`ifdef FPU_WB_IRQ_EN
      8'h20: if (sel[0]) m_irqen = d[0];
`endif
      8'h1C: begin
        op_full = ({20'b0, m_op} & ~mk) | (d & mk);
        if (sel[1] && d[12]) begin
          if (m_busy) begin
            m_errov = 1'b1;
          end else begin
            m_op = op_full[11:0];
            exp_a = m_a; exp_b = m_b; exp_c = m_c; exp_rm = m_rm;
            exp_op = op_full[11:0];
            m_busy = 1'b1; m_done = 1'b0; m_errov = 1'b0; m_errto = 1'b0;
            exp_pulses++;
          end
        end else begin
          m_op = op_full[11:0];
        end
      end
      default: ;
    endcase
  endtask

  // One bus transaction with a bounded wait for ack.
  task automatic wbXfer(input logic we, input logic [31:0] adr,
                        input logic [31:0] wdata, input logic [3:0] sel,
                        output logic [31:0] rdata, output logic acked);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = sel; bus.wbs_adr_i = adr; bus.wbs_dat_i = wdata;
    acked = 1'b0;
    rdata = '0;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) begin
        acked = 1'b1;
        rdata = bus.wbs_dat_o;
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic wbWrite(input logic [7:0] ofs, input logic [31:0] d,
                         input logic [3:0] sel);
    logic [31:0] rd;
    logic ak;
    wbXfer(1'b1, {BASE[31:8], ofs}, d, sel, rd, ak);
    checkOutput("write_ack", ak, 1'b1);
    if (ak) model_write(ofs, d, sel);
  endtask

  task automatic wbRead(input logic [7:0] ofs, input string name,
                        output logic [31:0] rd);
    logic [31:0] expv;
    logic ak;
    expv = model_read(ofs);
    wbXfer(1'b0, {BASE[31:8], ofs}, 32'h0, 4'hF, rd, ak);
    checkOutput({name, "_ack"}, ak, 1'b1);
    checkOutput(name, rd, expv);
    if (ak && ofs == 8'h0C) m_done = 1'b0;
  endtask

  task automatic fpuReply(input int delay, input logic [31:0] res,
                          input logic [4:0] fl);
    repeat (delay) @(posedge clk);
    @(negedge clk);
    fpu_valid = 1'b1; fpu_result = res; fpu_flags = fl;
    @(posedge clk);
    #1;
    fpu_valid = 1'b0;
    if (m_busy) begin
      m_result = res; m_flags = fl; m_done = 1'b1; m_busy = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int iters);
    logic [7:0]  ofs_list [10];
    logic [31:0] rd, opw;
    ofs_list = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24};
    for (int it = 0; it < iters; it++) begin
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        case ($urandom_range(0, 4))
          0: wbWrite(8'h00, $urandom, 4'($urandom));
          1: wbWrite(8'h04, $urandom, 4'($urandom));
          2: wbWrite(8'h08, $urandom, 4'($urandom));
          3: wbWrite(8'h24, $urandom, 4'($urandom));
          default: wbWrite(8'h20, $urandom, 4'($urandom));
        endcase
      end
      wbRead(ofs_list[$urandom_range(0, 9)], "rand_read", rd);
      opw = $urandom;
      opw[12] = ($urandom_range(0, 3) != 0);
      wbWrite(8'h1C, opw, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
      if (m_busy) begin
        if ($urandom_range(0, 3) == 0) wbWrite(8'h1C, $urandom | 32'h1000, 4'hF);
        if ($urandom_range(0, 1) == 1) wbWrite(8'h00, $urandom, 4'hF);
        fpuReply($urandom_range(1, 6), $urandom, 5'($urandom));
        wbRead(8'h14, "rand_status", rd);
        wbRead(8'h10, "rand_flags", rd);
        wbRead(8'h0C, "rand_result", rd);
        wbRead(8'h14, "rand_status_after_rd", rd);
      end
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        seen_pulses++;
        checkOutput("launch_count", seen_pulses, exp_pulses);
        checkOutput("launch_operands", {a_o, b_o, c_o}, {exp_a, exp_b, exp_c});
        checkOutput("launch_op_rm", {op_o, rm_o}, {exp_op, exp_rm});
      end
      checkOutput("irq_level", irq_o, model_irq());
      checkOutput("ack_single", ack_prev & bus.wbs_ack_o, 1'b0);
    end
    ack_prev = bus.wbs_ack_o;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic ak;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
    model_reset();
    exp_a = '0; exp_b = '0; exp_c = '0; exp_op = '0; exp_rm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    checkOutput("reset_outputs", {a_o, b_o, c_o, op_o, rm_o, valid_o, irq_o}, '0);
    wbRead(8'h14, "reset_status", rd);
    checkOutput("reset_status_lit", rd, 32'h0);

    // Basic add.
    wbWrite(8'h00, 32'h3F80_0000, 4'hF);
    wbWrite(8'h04, 32'h4000_0000, 4'hF);
    wbWrite(8'h24, 32'h0, 4'hF);
    wbWrite(8'h1C, 32'h0000_1001, 4'hF);
    checkOutput("add_valid_pulse", valid_o, 1'b1);
    checkOutput("add_operands_lit", {a_o, b_o, op_o}, {32'h3F80_0000, 32'h4000_0000, OP_ADD});
    fpuReply(1, 32'h4040_0000, 5'h0);
    wbRead(8'h14, "add_status", rd);
    checkOutput("add_status_lit", rd, 32'h2);
    wbRead(8'h0C, "add_result", rd);
    checkOutput("add_result_lit", rd, 32'h4040_0000);
    wbRead(8'h14, "status_after_result_rd", rd);
    checkOutput("done_cleared_lit", rd, 32'h0);
    wbRead(8'h1C, "op_readback", rd);
    checkOutput("op_valid_reads0_lit", rd, 32'h001);

    // Timeout: no FPU reply.
    wbWrite(8'h1C, 32'h0000_1004, 4'hF);
    repeat (150) @(posedge clk);
    wbRead(8'h14, "timeout_busy", rd);
    checkOutput("timeout_busy_lit", rd, 32'h1);
    repeat (150) @(posedge clk);
    m_busy = 1'b0;
    m_errto = 1'b1;
    wbRead(8'h14, "timeout_status", rd);
    checkOutput("timeout_status_lit", rd, 32'h8);
    wbRead(8'h0C, "timeout_result", rd);
    checkOutput("timeout_result_lit", rd, 32'h4040_0000);

    // Overrun: second valid OP while busy is dropped.
    wbWrite(8'h1C, 32'h0000_1002, 4'hF);
    wbWrite(8'h1C, 32'h0000_1004, 4'hF);
    wbRead(8'h14, "overrun_status", rd);
    checkOutput("overrun_status_lit", rd, 32'h5);
    wbRead(8'h1C, "overrun_op", rd);
    checkOutput("overrun_op_lit", rd, 32'h002);
    fpuReply(2, 32'hC000_0000, 5'h01);
    wbRead(8'h14, "overrun_done_status", rd);
    checkOutput("overrun_done_lit", rd, 32'h6);
    checkOutput("overrun_pulses", seen_pulses, 3);

    // Byte selects and unmapped offsets.
    wbWrite(8'h00, 32'h0, 4'hF);
    wbWrite(8'h00, 32'hFFFF_FFFF, 4'b0011);
    wbRead(8'h00, "sel_a", rd);
    checkOutput("sel_a_lit", rd, 32'h0000_FFFF);
    wbRead(8'h18, "unmapped_18", rd);
    checkOutput("unmapped_18_lit", rd, 32'h0);
    wbRead(8'h28, "unmapped_28", rd);
    wbXfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, rd, ak);
    checkOutput("outside_window_no_ack", ak, 1'b0);

    // Interrupt.
    wbWrite(8'h20, 32'h1, 4'hF);
    wbWrite(8'h1C, 32'h0000_1001, 4'hF);
    fpuReply(1, 32'h3F80_0000, 5'h0);
`ifdef FPU_WB_IRQ_EN
    checkOutput("irq_set_lit", irq_o, 1'b1);
    wbRead(8'h0C, "irq_result", rd);
    checkOutput("irq_clear_on_read_lit", irq_o, 1'b0);
    wbWrite(8'h1C, 32'h0000_1001, 4'hF);
    fpuReply(1, 32'h4000_0000, 5'h0);
    checkOutput("irq_set2_lit", irq_o, 1'b1);
    wbWrite(8'h20, 32'h0, 4'hF);
    checkOutput("irq_clear_on_irqen0_lit", irq_o, 1'b0);
`else
    checkOutput("irq_tied0_lit", irq_o, 1'b0);
    wbRead(8'h20, "irqen_unmapped", rd);
    checkOutput("irqen_unmapped_lit", rd, 32'h0);
`endif

    // Randomized traffic.
    applyStimulus(40);

    // Reset during WAIT, then a late FPU reply.
    wbWrite(8'h00, 32'h1234_5678, 4'hF);
    wbWrite(8'h1C, 32'h0000_1008, 4'hF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    fpuReply(1, 32'hDEAD_BEEF, 5'h1F);
    wbRead(8'h0C, "rst_result", rd);
    checkOutput("rst_result_lit", rd, 32'h0);
    wbRead(8'h14, "rst_status", rd);
    checkOutput("rst_status_lit", rd, 32'h0);
    wbRead(8'h00, "rst_a", rd);
    checkOutput("rst_a_lit", rd, 32'h0);
    wbRead(8'h10, "rst_flags", rd);
    wbRead(8'h1C, "rst_op", rd);
    checkOutput("rst_outputs", {a_o, b_o, c_o, op_o, rm_o, valid_o, irq_o}, '0);

    checkOutput("launch_total", seen_pulses, exp_pulses);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
